jk_bank_ctrl: RTL and testbench

//   Sequencer for a bank of N JK flip-flops sharing one clock. Accepts HOLD, RESET,
//   SET and TOGGLE commands on a valid/ready handshake, applies a per-bit mask and a

---
 rtl/jk_bank_ctrl.sv | 118 +++++++++++
 tb/tb_jk_bank_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops: drives masked J/K patterns for a
// programmable number of cycles, then compares the bank against its predicted value.
module jk_bank_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [N-1:0]     cmd_mask,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic [N-1:0]     jk_j,
  output logic [N-1:0]     jk_k,
  input  logic [N-1:0]     ff_q,
  output logic [N-1:0]     exp_q,
  output logic [N-1:0]     mismatch,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

  localparam logic [1:0] OpHold   = 2'b00;
  localparam logic [1:0] OpReset  = 2'b01;
  localparam logic [1:0] OpSet    = 2'b10;
  localparam logic [1:0] OpToggle = 2'b11;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [N-1:0]     mask_q;
  logic [CNT_W-1:0] rep_cnt_q;

  logic [N-1:0] op_val;
  logic [N-1:0] exp_next;
  logic [N-1:0] diff;

  // Value the masked bits take after one more drive cycle of the latched op.
  always_comb begin
    op_val = exp_q;
    case (op_q)
      OpHold:   op_val = exp_q;
      OpReset:  op_val = '0;
      OpSet:    op_val = '1;
      OpToggle: op_val = ~exp_q;
      default:  op_val = exp_q;
    endcase
    exp_next = (exp_q & ~mask_q) | (op_val & mask_q);
    diff     = ff_q ^ exp_q;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= StIdle;
      op_q      <= OpHold;
      mask_q    <= '0;
      rep_cnt_q <= '0;
      cmd_ready <= 1'b0;
      jk_j      <= '0;
      jk_k      <= '0;
      exp_q     <= '0;
      mismatch  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            mask_q    <= cmd_mask;
            rep_cnt_q <= cmd_rep;
            exp_q     <= ff_q;
            jk_j      <= cmd_op[1] ? cmd_mask : '0;
            jk_k      <= cmd_op[0] ? cmd_mask : '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StDrive;
          end else begin
            cmd_ready <= 1'b1;
            jk_j      <= '0;
            jk_k      <= '0;
          end
        end
        StDrive: begin
          exp_q <= exp_next;
          if (rep_cnt_q != '0) begin
            rep_cnt_q <= rep_cnt_q - CNT_W'(1);
          end else begin
            jk_j    <= '0;
            jk_k    <= '0;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          mismatch  <= diff;
          done      <= 1'b1;
          err       <= |diff;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          jk_j      <= '0;
          jk_k      <= '0;
          busy      <= 1'b0;
          cmd_ready <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl with a behavioural JK bank and a stuck-at-1 hook.
module tb_jk_bank_ctrl;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [3:0] cmd_rep;
  logic [3:0] jk_j;
  logic [3:0] jk_k;
  logic [3:0] ff_q;
  logic [3:0] exp_q;
  logic [3:0] mismatch;
  logic       busy;
  logic       done;
  logic       err;

  logic [3:0] bank_q;
  logic [3:0] stuck;
  logic       load_en;
  logic [3:0] load_val;

  int tests  = 0;
  int failed = 0;
  int n;
  int done_cnt;

  always #5 CLK = ~CLK;

  jk_bank_ctrl #(.N(4), .CNT_W(4)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_rep   (cmd_rep),
    .jk_j      (jk_j),
    .jk_k      (jk_k),
    .ff_q      (ff_q),
    .exp_q     (exp_q),
    .mismatch  (mismatch),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // JK characteristic: Q+ = J&~Q | ~K&Q
  always @(posedge CLK) begin
    if (load_en) bank_q <= load_val;
    else         bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
  end

  assign ff_q = bank_q | stuck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] mask, input logic [3:0] rep);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_rep   = rep;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      @(negedge CLK);
      cycles++;
    end
  endtask

  initial begin
    RST_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_mask  = 4'h0;
    cmd_rep   = 4'h0;
    stuck     = 4'h0;
    load_en   = 1'b1;
    load_val  = 4'h0;

    // 1: reset
    #1 RST_n = 1'b0;
    #1;
    check("rst_j", jk_j, 4'h0);
    check("rst_k", jk_k, 4'h0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_ready, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;
    check("ready_before_edge", cmd_ready, 1'b0);
    @(negedge CLK);
    check("ready_after_edge", cmd_ready, 1'b1);
    load_en = 1'b0;

    // 2: SET mask 0101 rep 0 from 0000
    send(2'b10, 4'b0101, 4'd0);
    check("t2_j", jk_j, 4'b0101);
    check("t2_k", jk_k, 4'b0000);
    check("t2_busy", busy, 1'b1);
    check("t2_ready", cmd_ready, 1'b0);
    @(negedge CLK);
    check("t2_j_off", jk_j, 4'b0000);
    check("t2_no_done_yet", done, 1'b0);
    @(negedge CLK);
    check("t2_done", done, 1'b1);
    check("t2_err", err, 1'b0);
    check("t2_exp", exp_q, 4'b0101);
    check("t2_mis", mismatch, 4'b0000);
    check("t2_busy_clr", busy, 1'b0);
    check("t2_ready_back", cmd_ready, 1'b1);
    @(negedge CLK);
    check("t2_done_pulse", done, 1'b0);
    check("t2_exp_hold", exp_q, 4'b0101);

    // 3: TOGGLE mask 1111 rep 2 from 0101
    send(2'b11, 4'b1111, 4'd2);
    check("t3_j0", jk_j, 4'b1111);
    check("t3_k0", jk_k, 4'b1111);
    @(negedge CLK);
    check("t3_j1", jk_j, 4'b1111);
    @(negedge CLK);
    check("t3_k2", jk_k, 4'b1111);
    @(negedge CLK);
    check("t3_j_off", jk_j, 4'b0000);
    check("t3_not_done", done, 1'b0);
    wait_done(n);
    check("t3_latency", n, 1);
    check("t3_exp", exp_q, 4'b1010);
    check("t3_err", err, 1'b0);
    check("t3_mis", mismatch, 4'b0000);
    @(negedge CLK);

    // 4: bit0 stuck at 1, RESET mask 1111 rep 0
    stuck = 4'b0001;
    @(negedge CLK);
    send(2'b01, 4'b1111, 4'd0);
    check("t4_j", jk_j, 4'b0000);
    check("t4_k", jk_k, 4'b1111);
    wait_done(n);
    check("t4_latency", n, 2);
    check("t4_exp", exp_q, 4'b0000);
    check("t4_err", err, 1'b1);
    check("t4_mis", mismatch, 4'b0001);
    stuck = 4'b0000;
    @(negedge CLK);
    check("t4_err_pulse", err, 1'b0);
    check("t4_mis_hold", mismatch, 4'b0001);

    // 5: HOLD with valid held through busy; second command taken in the done cycle
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_mask  = 4'b1111;
    cmd_rep   = 4'd0;
    @(negedge CLK);
    check("t5_j", jk_j, 4'b0000);
    check("t5_k", jk_k, 4'b0000);
    check("t5_busy", busy, 1'b1);
    check("t5_ready_low", cmd_ready, 1'b0);
    @(negedge CLK);
    check("t5_no_early_done", done, 1'b0);
    @(negedge CLK);
    check("t5_done", done, 1'b1);
    check("t5_err", err, 1'b0);
    check("t5_exp", exp_q, 4'b0000);
    check("t5_ready_in_done", cmd_ready, 1'b1);
    cmd_op   = 2'b10;
    cmd_mask = 4'b0011;
    cmd_rep  = 4'd1;
    @(negedge CLK);
    check("t5_single_done", done, 1'b0);
    check("t5_second_busy", busy, 1'b1);
    check("t5_second_j", jk_j, 4'b0011);
    check("t5_second_k", jk_k, 4'b0000);
    cmd_valid = 1'b0;
    wait_done(n);
    check("t5_second_latency", n, 3);
    check("t5_second_exp", exp_q, 4'b0011);
    check("t5_second_err", err, 1'b0);
    @(negedge CLK);

    // 6: reset during a long TOGGLE drive, then a normal SET
    send(2'b11, 4'b1111, 4'd5);
    @(negedge CLK);
    @(negedge CLK);
    check("t6_driving", jk_j, 4'b1111);
    #2 RST_n = 1'b0;
    #1;
    check("t6_async_j", jk_j, 4'b0000);
    check("t6_async_k", jk_k, 4'b0000);
    check("t6_async_busy", busy, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST_n    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (done === 1'b1) done_cnt++;
    end
    check("t6_no_done", done_cnt, 0);
    check("t6_ready", cmd_ready, 1'b1);
    send(2'b10, 4'b1100, 4'd0);
    wait_done(n);
    check("t6_set_latency", n, 2);
    check("t6_set_exp", exp_q, 4'b1111);
    check("t6_set_err", err, 1'b0);
    check("t6_set_mis", mismatch, 4'b0000);
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
